// File: rtl/pipelined_adder_nbit_if.sv
// Valid/ready bus for pipelined_adder_nbit: operands in, sum/carry out.
// Optional overflow flag V is present only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_nbit_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPE_ADDER_OVF_EN
    logic             V;

    modport master (
        output A, B, Cin, in_valid, out_ready,
        input  in_ready, S, Cout, out_valid, V
    );
    modport slave (
        input  A, B, Cin, in_valid, out_ready,
        output in_ready, S, Cout, out_valid, V
    );
`else
    modport master (
        output A, B, Cin, in_valid, out_ready,
        input  in_ready, S, Cout, out_valid
    );
    modport slave (
        input  A, B, Cin, in_valid, out_ready,
        output in_ready, S, Cout, out_valid
    );
`endif
endinterface

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit adder split into WIDTH/SEG_WIDTH ripple segments, one per pipeline stage,
// with skewed operands and deskewed sum. Define PIPE_ADDER_OVF_EN to add overflow flag V.
module pipelined_adder_nbit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEG_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipelined_adder_nbit_if.slave bus
);
    localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
    localparam int unsigned SW1  = SEG_WIDTH + 1;

    logic                 w_adv;
    logic                 w_accept;
    logic                 w_c     [NSEG];
    logic                 w_v     [NSEG];
    logic [SEG_WIDTH-1:0] w_s_seg [NSEG];

    // Whole pipeline moves together; it freezes only when a result is waiting unaccepted.
    assign w_adv        = ~w_v[NSEG-1] | bus.out_ready;
    assign w_accept     = bus.in_valid & w_adv;
    assign bus.in_ready = w_adv;
    assign bus.Cout     = w_c[NSEG-1];
    assign bus.out_valid = w_v[NSEG-1];

    always_comb begin
        bus.S = '0;
        for (int i = 0; i < int'(NSEG); i++) begin
            bus.S[i*SEG_WIDTH +: SEG_WIDTH] = w_s_seg[i];
        end
    end

    for (genvar j = 0; j < int'(NSEG); j++) begin : g_seg
        logic [SEG_WIDTH-1:0] w_a;
        logic [SEG_WIDTH-1:0] w_b;
        logic                 w_cin;
        logic                 w_vin;
        logic [SW1-1:0]       w_add;
        logic [SEG_WIDTH-1:0] r_sum;
        logic                 r_c;
        logic                 r_v;

        if (j == 0) begin : g_head
            assign w_a   = bus.A[SEG_WIDTH-1:0];
            assign w_b   = bus.B[SEG_WIDTH-1:0];
            assign w_cin = bus.Cin;
            assign w_vin = w_accept;
        end else begin : g_skew
            // Operand segment j waits j cycles so it meets the carry from segment j-1.
            logic [SEG_WIDTH-1:0] r_a_sk [j];
            logic [SEG_WIDTH-1:0] r_b_sk [j];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < j; i++) begin
                        r_a_sk[i] <= '0;
                        r_b_sk[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_a_sk[0] <= bus.A[j*SEG_WIDTH +: SEG_WIDTH];
                    r_b_sk[0] <= bus.B[j*SEG_WIDTH +: SEG_WIDTH];
                    for (int i = 1; i < j; i++) begin
                        r_a_sk[i] <= r_a_sk[i-1];
                        r_b_sk[i] <= r_b_sk[i-1];
                    end
                end
            end

            assign w_a   = r_a_sk[j-1];
            assign w_b   = r_b_sk[j-1];
            assign w_cin = w_c[j-1];
            assign w_vin = w_v[j-1];
        end

        assign w_add = SW1'(w_a) + SW1'(w_b) + SW1'(w_cin);

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_sum <= '0;
                r_c   <= 1'b0;
                r_v   <= 1'b0;
            end else if (w_adv) begin
                r_sum <= w_add[SEG_WIDTH-1:0];
                r_c   <= w_add[SEG_WIDTH];
                r_v   <= w_vin;
            end
        end

        assign w_c[j] = r_c;
        assign w_v[j] = r_v;

        if (j < int'(NSEG) - 1) begin : g_dsk
            // Early sum segments wait for the top segment to finish.
            localparam int unsigned D = NSEG - 1 - j;
            logic [SEG_WIDTH-1:0] r_s_dsk [D];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < int'(D); i++) begin
                        r_s_dsk[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_s_dsk[0] <= r_sum;
                    for (int i = 1; i < int'(D); i++) begin
                        r_s_dsk[i] <= r_s_dsk[i-1];
                    end
                end
            end

            assign w_s_seg[j] = r_s_dsk[D-1];
        end else begin : g_last
            assign w_s_seg[j] = r_sum;
`ifdef PIPE_ADDER_OVF_EN
            // a^b^s at the MSB recovers the carry into the MSB.
            logic r_ovf;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_a[SEG_WIDTH-1] ^ w_b[SEG_WIDTH-1]
                           ^ w_add[SEG_WIDTH-1] ^ w_add[SEG_WIDTH];
                end
            end

            assign bus.V = r_ovf;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit (WIDTH=16, SEG_WIDTH=4): directed table,
// streaming, backpressure, toggling out_ready and mid-stream reset.
module tb_pipelined_adder_nbit;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned SEG_WIDTH = 4;
    localparam int unsigned NSEG      = WIDTH / SEG_WIDTH;
    localparam int          NVEC      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_nbit_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder_nbit #(.WIDTH(WIDTH), .SEG_WIDTH(SEG_WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        v;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        v;
    } res_t;

    vec_t vecs [NVEC];
    res_t exp_q [$];
    res_t mon_r;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        res_t r;
        int   sv;
        {r.cout, r.s} = 17'(a) + 17'(b) + 17'(cin);
        sv  = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r.v = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    // Scoreboard: outputs compared in acceptance order; transfers observed mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got S=0x%0h, expected no result", bus.S);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("sb_S", 32'(bus.S), 32'(mon_r.s));
                    chk("sb_Cout", 32'(bus.Cout), 32'(mon_r.cout));
`ifdef PIPE_ADDER_OVF_EN
                    chk("sb_V", 32'(bus.V), 32'(mon_r.v));
`endif
                    pops++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.Cin));
            end
        end
    end

    // One vector into an idle pipe: exact latency, values, single pulse.
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
        bus.A = v.a;
        bus.B = v.b;
        bus.Cin = v.cin;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k < int'(NSEG); k++) begin
            chk("vec_early_valid", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("vec_out_valid", 32'(bus.out_valid), 32'd1);
        chk("vec_S", 32'(bus.S), 32'(v.s));
        chk("vec_Cout", 32'(bus.Cout), 32'(v.cout));
`ifdef PIPE_ADDER_OVF_EN
        chk("vec_V", 32'(bus.V), 32'(v.v));
`endif
        @(posedge clk); #1;
        chk("vec_one_pulse", 32'(bus.out_valid), 32'd0);
    endtask

    // Present one operand pair until accepted; returns cycles spent.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected accept");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        int   tot;
        int   p0;
        res_t first;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
        vecs[8] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_Cout", 32'(bus.Cout), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Streaming at full rate.
        p0 = pops;
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rc, cyc);
            tot += cyc;
        end
        drain();
        chk("stream_cycles", 32'(tot), 32'd20);
        chk("stream_count", 32'(pops - p0), 32'd20);

        // Backpressure with a full pipeline.
        bus.out_ready = 1'b0;
        p0 = pops;
        first = model(16'h1000, 16'h0234, 1'b1);
        send(16'h1000, 16'h0234, 1'b1, cyc);
        send(16'hFFFF, 16'h0001, 1'b0, cyc);
        send(16'h4321, 16'h1234, 1'b0, cyc);
        send(16'h8001, 16'h8001, 1'b1, cyc);
        for (int k = 0; k < 6; k++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_S_steady", 32'(bus.S), 32'(first.s));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(pops - p0), 32'd4);

        // Toggling out_ready while streaming.
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'(16'h1111 * i), 16'(16'h0F0F + i), 1'(i), cyc);
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); #1;
                    bus.out_ready = ~bus.out_ready;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("toggle_count", 32'(pops - p0), 32'd8);

        // Asynchronous reset with results in flight.
        send(16'h0101, 16'h0202, 1'b0, cyc);
        send(16'h0303, 16'h0404, 1'b0, cyc);
        send(16'h0505, 16'h0606, 1'b0, cyc);
        send(16'h0707, 16'h0808, 1'b1, cyc);
        chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_S", 32'(bus.S), 32'd0);
        chk("mr_Cout", 32'(bus.Cout), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("mr_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Pipeline still works after reset.
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
